// File: rtl/ap_job_sequencer_if.sv
// Signal bundle between the job sequencer, its host/result consumer and the AP array.
// master = sequencer side, slave = host plus array side.
interface ap_job_sequencer_if #(
    parameter int WORD_SIZE = 8,
    parameter int AW        = 10
);
    logic                   job_start;
    logic [2:0]             job_cmd;
    logic                   job_dir;
    logic [AW:0]            job_count;
    logic                   job_busy;
    logic                   job_done;
    logic                   job_err;

    logic                   op_valid;
    logic                   op_ready;
    logic [2*WORD_SIZE-1:0] op_data;

    logic                   res_valid;
    logic                   res_ready;
    logic [WORD_SIZE-1:0]   res_data;
    logic                   res_last;

    logic                   ap_rst;
    logic                   ap_mode;
    logic [2:0]             ap_cmd;
    logic                   ap_dir;
    logic [1:0]             ap_sel_col;
    logic                   ap_sel_internal_col;
    logic [AW-1:0]          ap_addr;
    logic [WORD_SIZE-1:0]   ap_wdata;
    logic                   ap_write_en;
    logic                   ap_read_en;
    logic                   ap_irq;
    logic [WORD_SIZE-1:0]   ap_rdata;

    modport master (
        input  job_start, job_cmd, job_dir, job_count,
        output job_busy, job_done, job_err,
        input  op_valid, op_data,
        output op_ready,
        output res_valid, res_data, res_last,
        input  res_ready,
        output ap_rst, ap_mode, ap_cmd, ap_dir, ap_sel_col, ap_sel_internal_col,
        output ap_addr, ap_wdata, ap_write_en, ap_read_en,
        input  ap_irq, ap_rdata
    );

    modport slave (
        output job_start, job_cmd, job_dir, job_count,
        input  job_busy, job_done, job_err,
        output op_valid, op_data,
        input  op_ready,
        input  res_valid, res_data, res_last,
        output res_ready,
        input  ap_rst, ap_mode, ap_cmd, ap_dir, ap_sel_col, ap_sel_internal_col,
        input  ap_addr, ap_wdata, ap_write_en, ap_read_en,
        output ap_irq, ap_rdata
    );
endinterface

// File: rtl/ap_job_sequencer.sv
// Loads operand pairs into AP columns A/B, runs one command until the array interrupt,
// then streams column C back out as a valid/ready result stream.
//   state      | meaning
//   IDLE       | wait for job_start, reject bad counts
//   CLEAR      | one-cycle array reset
//   LOAD_A/B   | write a into column A, then b into column B
//   RUN_START  | strobe-free gap before run mode
//   RUN        | array running, timeout armed
//   DRAIN_*    | read request, latency wait, result handshake
//   DONE       | successful completion pulse
module ap_job_sequencer #(
    parameter int WORD_SIZE      = 8,
    parameter int CELL_QUANT     = 512,
    parameter int READ_LAT       = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                clk_i,
    input logic                rst_i,
    ap_job_sequencer_if.master bus
);
    localparam int AW = $clog2(CELL_QUANT);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] CLEAR      = 4'd1;
    localparam logic [3:0] LOAD_A     = 4'd2;
    localparam logic [3:0] LOAD_B     = 4'd3;
    localparam logic [3:0] RUN_START  = 4'd4;
    localparam logic [3:0] RUN        = 4'd5;
    localparam logic [3:0] DRAIN_REQ  = 4'd6;
    localparam logic [3:0] DRAIN_WAIT = 4'd7;
    localparam logic [3:0] DRAIN_OUT  = 4'd8;
    localparam logic [3:0] DONE       = 4'd9;

    logic [3:0]           state_q, state_d;
    logic [2:0]           cmd_q, cmd_d;
    logic                 dir_q, dir_d;
    logic [AW:0]          count_q, count_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [LW-1:0]        lat_q, lat_d;
    logic [WORD_SIZE-1:0] res_data_q, res_data_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_last_q, res_last_d;
    logic                 abort_q, abort_d;
    logic                 at_last;
    logic                 count_bad;

    assign at_last   = ({1'b0, addr_q} == (count_q - (AW+1)'(1)));
    assign count_bad = (bus.job_count == '0) || (bus.job_count > (AW+1)'(CELL_QUANT));

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        dir_d       = dir_q;
        count_d     = count_q;
        addr_d      = addr_q;
        b_d         = b_q;
        tmr_d       = tmr_q;
        lat_d       = lat_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        abort_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.job_start) begin
                    cmd_d   = bus.job_cmd;
                    dir_d   = bus.job_dir;
                    count_d = bus.job_count;
                    if (count_bad) abort_d = 1'b1;
                    else           state_d = CLEAR;
                end
            end
            CLEAR: begin
                addr_d  = '0;
                state_d = LOAD_A;
            end
            LOAD_A: begin
                if (bus.op_valid) begin
                    b_d     = bus.op_data[2*WORD_SIZE-1:WORD_SIZE];
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (at_last) begin
                    state_d = RUN_START;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = LOAD_A;
                end
            end
            RUN_START: begin
                tmr_d   = TW'(TIMEOUT_CYCLES - 1);
                state_d = RUN;
            end
            RUN: begin
                // the interrupt takes priority over an expiring timer
                if (bus.ap_irq) begin
                    addr_d  = '0;
                    state_d = DRAIN_REQ;
                end else if (tmr_q == '0) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            DRAIN_REQ: begin
                lat_d   = LW'(READ_LAT - 1);
                state_d = DRAIN_WAIT;
            end
            DRAIN_WAIT: begin
                if (lat_q == '0) begin
                    res_data_d  = bus.ap_rdata;
                    res_valid_d = 1'b1;
                    res_last_d  = at_last;
                    state_d     = DRAIN_OUT;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            DRAIN_OUT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    if (res_last_q) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = DRAIN_REQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            dir_q       <= 1'b0;
            count_q     <= '0;
            addr_q      <= '0;
            b_q         <= '0;
            tmr_q       <= '0;
            lat_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            dir_q       <= dir_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            b_q         <= b_d;
            tmr_q       <= tmr_d;
            lat_q       <= lat_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            abort_q     <= abort_d;
        end
    end

    // array strobes and column muxing; everything forced quiet while rst is high
    always_comb begin
        bus.op_ready    = 1'b0;
        bus.ap_write_en = 1'b0;
        bus.ap_read_en  = 1'b0;
        bus.ap_sel_col  = 2'd0;
        bus.ap_addr     = '0;
        bus.ap_wdata    = '0;
        if (!rst_i) begin
            case (state_q)
                LOAD_A: begin
                    bus.op_ready    = 1'b1;
                    bus.ap_write_en = bus.op_valid;
                    bus.ap_addr     = addr_q;
                    bus.ap_wdata    = bus.op_data[WORD_SIZE-1:0];
                end
                LOAD_B: begin
                    bus.ap_write_en = 1'b1;
                    bus.ap_sel_col  = 2'd1;
                    bus.ap_addr     = addr_q;
                    bus.ap_wdata    = b_q;
                end
                DRAIN_REQ: begin
                    bus.ap_read_en = 1'b1;
                    bus.ap_sel_col = 2'd2;
                    bus.ap_addr    = addr_q;
                end
                DRAIN_WAIT, DRAIN_OUT: begin
                    bus.ap_sel_col = 2'd2;
                    bus.ap_addr    = addr_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.ap_rst              = rst_i || (state_q == CLEAR);
    assign bus.ap_mode             = !rst_i && (state_q == RUN);
    assign bus.ap_cmd              = rst_i ? 3'd0 : cmd_q;
    assign bus.ap_dir              = !rst_i && dir_q;
    assign bus.ap_sel_internal_col = 1'b0;
    assign bus.job_busy            = !rst_i && (state_q != IDLE);
    assign bus.job_done            = !rst_i && ((state_q == DONE) || abort_q);
    assign bus.job_err             = !rst_i && abort_q;
    assign bus.res_valid           = !rst_i && res_valid_q;
    assign bus.res_last            = !rst_i && res_last_q;
    assign bus.res_data            = rst_i ? '0 : res_data_q;
endmodule

// File: tb/tb_ap_job_sequencer.sv
// Directed bench for ap_job_sequencer: a table of jobs with hand-computed results, driven
// against a small AP array model, plus timeout, back-pressure and mid-drain reset sequences.
module tb_ap_job_sequencer;
    localparam int WS = 8;
    localparam int AW = 10;

    typedef struct packed {
        logic [2:0]  cmd;
        logic        dir;
        logic [10:0] count;
        logic [31:0] a;      // byte i = operand a of beat i
        logic [31:0] b;
        logic [31:0] exp;    // byte i = expected result of beat i
        logic        err;
        logic        stall;
    } job_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_aprst = 0;
    int   n_wr = 0;
    int   n_rd = 0;
    logic irq_en = 1'b1;
    logic [7:0] mode_cnt = 8'd0;
    logic [7:0] rd_p0 = 8'h00;
    logic [7:0] rd_p1 = 8'h00;
    logic       dir_cap = 1'b0;
    logic [7:0] col_a [0:511];
    logic [7:0] col_b [0:511];
    logic [7:0] col_c [0:511];
    job_vec_t   tbl [9];

    ap_job_sequencer_if #(.WORD_SIZE(WS), .AW(AW)) bus ();

    ap_job_sequencer #(
        .WORD_SIZE(WS), .CELL_QUANT(512), .READ_LAT(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = {8'h00, a} * {8'h00, b};
        case (c)
            3'd0:    return a | b;
            3'd1:    return a ^ b;
            3'd2:    return a & b;
            3'd3:    return ~a;
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return p[7:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic job_vec_t mkv(input logic [2:0] cmd, input logic dir, input logic [10:0] count,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] exp, input logic err, input logic stall);
        job_vec_t v;
        v.cmd = cmd; v.dir = dir; v.count = count; v.a = a; v.b = b;
        v.exp = exp; v.err = err; v.stall = stall;
        return v;
    endfunction

    // AP array model: column writes, compute on interrupt, READ_LAT=2 read pipeline
    always @(posedge clk) begin
        if (bus.ap_write_en) begin
            if (bus.ap_sel_col == 2'd0)      col_a[bus.ap_addr] <= bus.ap_wdata;
            else if (bus.ap_sel_col == 2'd1) col_b[bus.ap_addr] <= bus.ap_wdata;
        end
        rd_p0 <= bus.ap_read_en ? col_c[bus.ap_addr] : 8'hEE;
        rd_p1 <= rd_p0;
        mode_cnt <= bus.ap_mode ? mode_cnt + 8'd1 : 8'd0;
        bus.ap_irq <= irq_en && bus.ap_mode && (mode_cnt == 8'd3);
        if (irq_en && bus.ap_mode && (mode_cnt == 8'd3)) begin
            dir_cap <= bus.ap_dir;
            for (int i = 0; i < 512; i++) col_c[i] <= alu(bus.ap_cmd, col_a[i], col_b[i]);
        end
    end
    assign bus.ap_rdata = rd_p1;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.ap_rst)      n_aprst++;
            if (bus.ap_write_en) n_wr++;
            if (bus.ap_read_en)  n_rd++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_excl", {31'd0, bus.ap_write_en & bus.ap_read_en}, 32'd0);
            chk("mode_vs_strobe", {31'd0, bus.ap_mode & (bus.ap_write_en | bus.ap_read_en)}, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input job_vec_t v);
        bus.job_cmd   = v.cmd;
        bus.job_dir   = v.dir;
        bus.job_count = v.count;
        bus.job_start = 1'b1;
        tick();
        bus.job_start = 1'b0;
    endtask

    task automatic load_ops(input job_vec_t v);
        int cnt;
        for (int i = 0; i < int'(v.count); i++) begin
            bus.op_valid = 1'b1;
            bus.op_data  = {v.b[8*i +: 8], v.a[8*i +: 8]};
            cnt = 0;
            while (!bus.op_ready && cnt < 20) begin
                tick();
                cnt++;
            end
            chk("op_ready_wait", {31'd0, bus.op_ready}, 32'd1);
            tick();
        end
        bus.op_valid = 1'b0;
    endtask

    task automatic run_job(input int idx, input job_vec_t v);
        int n_rst0, n_wr0, n_rd0, cnt, rd_snap;
        logic [7:0] d_snap;
        logic       stable;
        n_rst0 = n_aprst; n_wr0 = n_wr; n_rd0 = n_rd;
        start_job(v);
        if (v.err) begin
            chk($sformatf("job%0d reject_done", idx), {31'd0, bus.job_done}, 32'd1);
            chk($sformatf("job%0d reject_err", idx), {31'd0, bus.job_err}, 32'd1);
            chk($sformatf("job%0d reject_busy", idx), {31'd0, bus.job_busy}, 32'd0);
            tick();
            chk($sformatf("job%0d reject_pulse", idx), {31'd0, bus.job_done}, 32'd0);
            chk($sformatf("job%0d reject_no_ap", idx),
                32'(n_aprst - n_rst0 + n_wr - n_wr0 + n_rd - n_rd0), 32'd0);
            return;
        end
        chk($sformatf("job%0d busy", idx), {31'd0, bus.job_busy}, 32'd1);
        chk($sformatf("job%0d clear_ap_rst", idx), {31'd0, bus.ap_rst}, 32'd1);
        load_ops(v);
        bus.res_ready = 1'b1;
        for (int j = 0; j < int'(v.count); j++) begin
            cnt = 0;
            while (!bus.res_valid && cnt < 100) begin
                tick();
                cnt++;
            end
            chk($sformatf("job%0d res_valid_wait[%0d]", idx, j), {31'd0, bus.res_valid}, 32'd1);
            chk($sformatf("job%0d res_data[%0d]", idx, j), {24'd0, bus.res_data}, {24'd0, v.exp[8*j +: 8]});
            chk($sformatf("job%0d res_last[%0d]", idx, j), {31'd0, bus.res_last},
                (j == int'(v.count) - 1) ? 32'd1 : 32'd0);
            if (v.stall && j == 1) begin
                bus.res_ready = 1'b0;
                d_snap  = bus.res_data;
                rd_snap = n_rd;
                stable  = 1'b1;
                repeat (10) begin
                    tick();
                    if (!bus.res_valid || bus.res_data !== d_snap || bus.res_last !== 1'b0) stable = 1'b0;
                end
                chk($sformatf("job%0d stall_stable", idx), {31'd0, stable}, 32'd1);
                chk($sformatf("job%0d stall_no_read", idx), 32'(n_rd - rd_snap), 32'd0);
                bus.res_ready = 1'b1;
            end
            tick();
        end
        chk($sformatf("job%0d done", idx), {31'd0, bus.job_done}, 32'd1);
        chk($sformatf("job%0d done_err", idx), {31'd0, bus.job_err}, 32'd0);
        tick();
        chk($sformatf("job%0d done_pulse", idx), {31'd0, bus.job_done}, 32'd0);
        chk($sformatf("job%0d idle", idx), {31'd0, bus.job_busy}, 32'd0);
        chk($sformatf("job%0d ap_rst_pulses", idx), 32'(n_aprst - n_rst0), 32'd1);
        chk($sformatf("job%0d writes", idx), 32'(n_wr - n_wr0), 32'(2 * int'(v.count)));
        chk($sformatf("job%0d reads", idx), 32'(n_rd - n_rd0), 32'(v.count));
        chk($sformatf("job%0d ap_dir", idx), {31'd0, dir_cap}, {31'd0, v.dir});
    endtask

    initial begin
        int cnt, run_cyc;
        logic seen_res;
        job_vec_t tv;
        // cmd: 0 OR, 1 XOR, 2 AND, 3 NOT, 4 ADD, 5 SUB, 6 MULT
        tbl[0] = mkv(3'd4, 1'b0, 11'd3,   32'h0000C805, 32'h00006403, 32'h00002C08, 1'b0, 1'b0);
        tbl[1] = mkv(3'd2, 1'b1, 11'd1,   32'h000000F0, 32'h0000003C, 32'h00000030, 1'b0, 1'b0);
        tbl[2] = mkv(3'd1, 1'b0, 11'd2,   32'h00000FAA, 32'h0000FF55, 32'h0000F0FF, 1'b0, 1'b0);
        tbl[3] = mkv(3'd5, 1'b0, 11'd4,   32'h0780000A, 32'h09800103, 32'hFE00FF07, 1'b0, 1'b1);
        tbl[4] = mkv(3'd6, 1'b1, 11'd2,   32'h0000100C, 32'h0000200B, 32'h00000084, 1'b0, 1'b0);
        tbl[5] = mkv(3'd4, 1'b0, 11'd0,   32'h0,        32'h0,        32'h0,        1'b1, 1'b0);
        tbl[6] = mkv(3'd4, 1'b0, 11'd513, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0);
        tbl[7] = mkv(3'd3, 1'b0, 11'd1,   32'h0000005A, 32'h00000000, 32'h000000A5, 1'b0, 1'b0);
        tbl[8] = mkv(3'd0, 1'b1, 11'd2,   32'h00008001, 32'h00000810, 32'h00008811, 1'b0, 1'b0);

        bus.job_start = 1'b0; bus.job_cmd = 3'd0; bus.job_dir = 1'b0; bus.job_count = '0;
        bus.op_valid = 1'b0; bus.op_data = '0; bus.res_ready = 1'b0;
        repeat (3) tick();
        chk("reset ap_rst", {31'd0, bus.ap_rst}, 32'd1);
        chk("reset outputs", {24'd0, bus.job_busy, bus.job_done, bus.job_err, bus.op_ready,
            bus.res_valid, bus.ap_mode, bus.ap_write_en, bus.ap_read_en}, 32'd0);
        chk("reset res_data", {24'd0, bus.res_data}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post-reset ap_rst", {31'd0, bus.ap_rst}, 32'd0);

        for (int i = 0; i < 9; i++) run_job(i, tbl[i]);

        // timeout: interrupt never fires
        irq_en = 1'b0;
        tv = tbl[1];
        start_job(tv);
        load_ops(tv);
        run_cyc = 0; seen_res = 1'b0; cnt = 0;
        while (!bus.job_done && cnt < 100) begin
            if (bus.ap_mode) run_cyc++;
            if (bus.res_valid) seen_res = 1'b1;
            tick();
            cnt++;
        end
        chk("timeout done", {31'd0, bus.job_done}, 32'd1);
        chk("timeout err", {31'd0, bus.job_err}, 32'd1);
        chk("timeout run cycles", 32'(run_cyc), 32'd16);
        chk("timeout mode drop", {31'd0, bus.ap_mode}, 32'd0);
        chk("timeout no res", {31'd0, seen_res}, 32'd0);
        tick();
        chk("timeout done pulse", {31'd0, bus.job_done}, 32'd0);
        irq_en = 1'b1;

        // reset while waiting on read latency
        tv = tbl[0];
        start_job(tv);
        load_ops(tv);
        cnt = 0;
        while (!bus.ap_read_en && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("mid-drain read_en wait", {31'd0, bus.ap_read_en}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("mid-drain reset outputs", {24'd0, bus.job_busy, bus.job_done, bus.job_err, bus.op_ready,
            bus.res_valid, bus.ap_mode, bus.ap_write_en, bus.ap_read_en}, 32'd0);
        chk("mid-drain reset ap_rst", {31'd0, bus.ap_rst}, 32'd1);
        rst = 1'b0;
        tick();
        chk("mid-drain silent", {29'd0, bus.job_done, bus.job_busy, bus.res_valid}, 32'd0);
        run_job(10, tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ap_job_sequencer.md
Name: ap_job_sequencer

Overview:
- Upstream controller for the associative-processor array (AP_s port set).
- Takes a job descriptor and a stream of operand pairs, writes operands into columns A and B, then runs one AP command until the array raises its done interrupt.
- Reads column C back and presents the results as a valid/ready stream, so a host or UART bridge never drives raw AP pins.

Parameters:
- WORD_SIZE, 8, operand/result width; matches the AP array word size.
- CELL_QUANT, 512, number of AP cells; address width AW = clogb2(CELL_QUANT) = 10.
- READ_LAT, 2, cycles from ap_read_en asserted to ap_rdata valid.
- TIMEOUT_CYCLES, 4096, maximum cycles in RUN before the job aborts.

Ports:
- CLK100MHZ  in  1  clock
- rst  in  1  synchronous active-high reset
- job_start  in  1  one-cycle job request; sampled only in IDLE
- job_cmd  in  3  AP command (0 OR, 1 XOR, 2 AND, 3 NOT, 4 ADD, 5 SUB, 6 MULT)
- job_dir  in  1  op direction (0 vertical, 1 horizontal)
- job_count  in  AW+1  number of cells to use, 1..CELL_QUANT
- job_busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse at job end
- job_err  out  1  valid with job_done; 1 means rejected or timed out
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accepted
- op_data  in  2*WORD_SIZE  {b, a}
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  WORD_SIZE  column-C word
- res_last  out  1  marks the final result beat
- ap_rst  out  1  reset to the array
- ap_mode  out  1  array run mode
- ap_cmd  out  3  command to the array
- ap_dir  out  1  op_direction to the array
- ap_sel_col  out  2  column select
- ap_sel_internal_col  out  1  tied 0
- ap_addr  out  AW  cell address
- ap_wdata  out  WORD_SIZE  write data
- ap_write_en  out  1  array write strobe
- ap_read_en  out  1  array read strobe
- ap_irq  in  1  array done interrupt (ap_state_irq)
- ap_rdata  in  WORD_SIZE  array read data

Behaviour:
- Reset values: all outputs 0, except ap_rst = 1 while rst is high. State returns to IDLE and all counters clear. Reset mid-job abandons the job silently, with no job_done.
- IDLE: if job_start is high, latch cmd, dir and count.
  - count == 0 or count > CELL_QUANT: job_done = 1 and job_err = 1 on the next cycle; stay IDLE.
  - Otherwise go to CLEAR.
- CLEAR: ap_rst = 1 for exactly one cycle; addr = 0; go to LOAD_A.
- LOAD_A: op_ready = 1. On op_valid & op_ready:
  - same cycle: ap_write_en = 1, ap_sel_col = 0, ap_addr = addr, ap_wdata = a;
  - latch b; go to LOAD_B.
  - No beat: ap_write_en = 0 and stay.
- LOAD_B: op_ready = 0. Drive ap_write_en = 1, ap_sel_col = 1, ap_addr = addr, ap_wdata = b.
  - If addr == count-1: go to RUN_START.
  - Else: addr += 1 and go to LOAD_A.
- RUN_START: ap_write_en = 0 and ap_mode = 0 for one cycle (lets the array's registered write enable drain); go to RUN.
- RUN: ap_mode = 1; ap_cmd and ap_dir hold the latched values.
  - Timer increments each cycle.
  - ap_irq == 1 → ap_mode = 0 next cycle, addr = 0, go to DRAIN_REQ.
  - Timer reaches TIMEOUT_CYCLES-1 without ap_irq → ap_mode = 0, job_done = 1, job_err = 1, go to IDLE.
  - If ap_irq and timeout coincide, ap_irq wins.
- DRAIN_REQ: ap_read_en = 1, ap_sel_col = 2, ap_addr = addr for one cycle; latency counter = 0; go to DRAIN_WAIT.
- DRAIN_WAIT: keep ap_sel_col = 2 and ap_addr stable.
  - After READ_LAT cycles, capture ap_rdata into res_data, set res_valid = 1, res_last = (addr == count-1), go to DRAIN_OUT.
- DRAIN_OUT: hold res_valid, res_data and res_last stable until res_ready.
  - On handshake: res_valid = 0.
  - If res_last: go to DONE.
  - Else: addr += 1 and go to DRAIN_REQ.
- DONE: job_done = 1, job_err = 0 for one cycle; go to IDLE.
- job_start while busy is ignored.
- ap_read_en and ap_write_en are never both high.
- ap_mode is never high while either strobe is high.
- Result width is WORD_SIZE; column-C bit 8 (carry) is not returned.
- Throughput: 2 cycles per loaded element, plus (READ_LAT + 2) cycles per drained element when res_ready is held high.

Test Plan:
- ADD, count = 3, pairs (5,3), (200,100), (0,0), res_ready = 1 → results 8, 44, 0; res_last on beat 3; job_done = 1, job_err = 0.
- AND, count = 1, pair (0xF0, 0x3C) → single result 0x30 with res_last = 1; exactly one ap_rst pulse per job.
- job_count = 0 → job_done and job_err high one cycle after job_start; no ap_* activity.
- ap_irq model never fires, TIMEOUT_CYCLES = 16 → job_err = 1 exactly 16 cycles into RUN; ap_mode drops; no res_valid.
- res_ready held low 10 cycles on beat 2 → res_data and res_last stay stable; no extra ap_read_en until the handshake.
- rst asserted during DRAIN_WAIT → all outputs 0 next cycle; a following job runs correctly from IDLE.
